// File: rtl/regfile_wb_pkg.sv
// Shared types and sizes for the regfile writeback arbiter.
// Used by regfile_wb_fifo and regfile_wb_arbiter.
package regfile_wb_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 32;
  localparam int WB_DATA_WIDTH  = 64;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Per-source result FIFO with wrap-bit pointers, head output and a onehot
// summary of every destination register it currently holds.
module regfile_wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int DEPTH      = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push,
  input  logic [REG_ADDR_WIDTH-1:0] push_rd,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [REG_ADDR_WIDTH-1:0] head_rd,
  output logic [DATA_WIDTH-1:0]     head_data,
  output logic [NUM_REGS-1:0]       all_rd
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]             wr_q, rd_q, count;
  logic [REG_ADDR_WIDTH-1:0] rd_mem   [DEPTH];
  logic [DATA_WIDTH-1:0]     data_mem [DEPTH];

  assign count     = wr_q - rd_q;
  assign empty     = (wr_q == rd_q);
  assign full      = ((wr_q ^ rd_q) == PW'(DEPTH));
  assign head_rd   = rd_mem[rd_q[AW-1:0]];
  assign head_data = data_mem[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which slots are valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_mem[wr_q[AW-1:0]]   <= push_rd;
      data_mem[wr_q[AW-1:0]] <= push_data;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [AW-1:0] offset;
    // NOTE: every comb output gets a default first so no path can infer a latch.
    all_rd = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = AW'(i) - rd_q[AW-1:0];
      if ({1'b0, offset} < count) all_rd[rd_mem[i]] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: buffers unit results per source and grants up to
// NR_WRITE_PORTS of them per cycle round-robin. Optional macro WB_ARB_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int NR_SRC         = 4,
  parameter int NR_WRITE_PORTS = 2,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                                             clk_i,
  input  logic                                             rst_ni,
  input  logic [NR_SRC-1:0]                                src_valid_i,
  output logic [NR_SRC-1:0]                                src_ready_o,
  input  logic [NR_SRC-1:0][REG_ADDR_WIDTH-1:0]            src_rd_i,
  input  logic [NR_SRC-1:0][DATA_WIDTH-1:0]                src_data_i,
  output logic [NR_WRITE_PORTS-1:0]                        we_o,
  output logic [NR_WRITE_PORTS-1:0][REG_ADDR_WIDTH-1:0]    waddr_o,
  output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]        wdata_o,
  output logic [NUM_REGS-1:0]                              pending_o
);

  localparam int SW = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

  logic [NR_SRC-1:0]                      full, empty, push, pop, grant, head_valid;
  logic [NR_SRC-1:0][REG_ADDR_WIDTH-1:0]  fifo_rd, head_rd;
  logic [NR_SRC-1:0][DATA_WIDTH-1:0]      fifo_data, head_data;
  logic [NR_SRC-1:0][NUM_REGS-1:0]        all_rd;
  logic [SW-1:0]                          rr_q, rr_d;

  assign src_ready_o = ~full;

  for (genvar g = 0; g < NR_SRC; g++) begin : g_fifo
    regfile_wb_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .push      (push[g]),
      .push_rd   (src_rd_i[g]),
      .push_data (src_data_i[g]),
      .pop       (pop[g]),
      .full      (full[g]),
      .empty     (empty[g]),
      .head_rd   (fifo_rd[g]),
      .head_data (fifo_data[g]),
      .all_rd    (all_rd[g])
    );
  end

`ifdef WB_ARB_BYPASS_EN
  // An empty source presents its live input as head; a granted bypass is never stored.
  always_comb begin
    for (int s = 0; s < NR_SRC; s++) begin
      head_valid[s] = !empty[s] || src_valid_i[s];
      head_rd[s]    = '0;
      head_data[s]  = '0;
      if (!empty[s]) begin
        head_rd[s]   = fifo_rd[s];
        head_data[s] = fifo_data[s];
      end else if (src_valid_i[s]) begin
        head_rd[s]   = src_rd_i[s];
        head_data[s] = src_data_i[s];
      end
      pop[s]  = grant[s] && !empty[s];
      push[s] = src_valid_i[s] && !full[s] && !(empty[s] && grant[s]);
    end
  end
`else
  assign head_valid = ~empty;
  assign head_rd    = fifo_rd;
  assign head_data  = fifo_data;
  assign pop        = grant;
  assign push       = src_valid_i & ~full;
`endif

  // Scan from rr_q; a head wins while ports remain and its rd is not yet taken.
  always_comb begin
    logic [NUM_REGS-1:0] taken;
    int                  used;
    int                  s;
    grant   = '0;
    we_o    = '0;
    waddr_o = '0;
    wdata_o = '0;
    taken   = '0;
    used    = 0;
    s       = 0;
    rr_d    = rr_q;
    for (int k = 0; k < NR_SRC; k++) begin
      s = (int'(rr_q) + k) % NR_SRC;
      if (head_valid[s] && used < NR_WRITE_PORTS && !taken[head_rd[s]]) begin
        grant[s]       = 1'b1;
        taken[head_rd[s]] = 1'b1;
        we_o[used]     = (head_rd[s] != '0);
        waddr_o[used]  = head_rd[s];
        wdata_o[used]  = head_data[s];
        used           = used + 1;
        rr_d           = SW'((s + 1) % NR_SRC);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

  always_comb begin
    pending_o = '0;
    for (int s = 0; s < NR_SRC; s++) pending_o = pending_o | all_rd[s];
    pending_o[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter against a queue-based
// model of the writeback rules; honours WB_ARB_BYPASS_EN when defined.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  import regfile_wb_pkg::*;

  localparam int NS = 4, NP = 2, DW = 64, DEPTH = 2;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 0;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 1;
`endif

  logic                    clk = 1'b0, rst_n = 1'b0;
  logic [NS-1:0]           src_valid = '0, src_ready;
  logic [NS-1:0][4:0]      src_rd = '0;
  logic [NS-1:0][DW-1:0]   src_data = '0;
  logic [NP-1:0]           we;
  logic [NP-1:0][4:0]      waddr;
  logic [NP-1:0][DW-1:0]   wdata;
  logic [31:0]             pending;

  int errors = 0, checks = 0;

  wb_entry_t q [NS][$];
  int        rr = 0;
  wb_entry_t m_in    [NS];
  bit        m_grant [NS], m_acc [NS], m_empty [NS];
  bit        m_any;
  int        m_last;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .NR_SRC(NS), .NR_WRITE_PORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_rd_i(src_rd), .src_data_i(src_data), .we_o(we), .waddr_o(waddr),
    .wdata_o(wdata), .pending_o(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, predict outputs from the queues, compare.
  task automatic apply(input logic [NS-1:0] v, input logic [NS-1:0][4:0] rd,
                       input logic [NS-1:0][DW-1:0] d);
    logic [NS-1:0]         e_ready;
    logic [NP-1:0]         e_we;
    logic [NP-1:0][4:0]    e_waddr;
    logic [NP-1:0][DW-1:0] e_wdata;
    bit   [NP-1:0]         dcare;
    logic [31:0]           e_pend;
    bit                    taken [32];
    int                    used, s;
    wb_entry_t             h;
    bit                    wd_bad;
    src_valid = v;
    for (int i = 0; i < NS; i++) begin
      src_rd[i]   = v[i] ? rd[i] : 'x;
      src_data[i] = v[i] ? d[i]  : 'x;
      m_in[i]     = '{rd: rd[i], data: d[i]};
      m_empty[i]  = (q[i].size() == 0);
      m_grant[i]  = 1'b0;
      e_ready[i]  = (q[i].size() < DEPTH);
      m_acc[i]    = v[i] && e_ready[i];
    end
    e_pend = '0;
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < q[i].size(); j++) e_pend[q[i][j].rd] = 1'b1;
    e_pend[0] = 1'b0;
    foreach (taken[r]) taken[r] = 1'b0;
    e_we = '0; e_waddr = '0; e_wdata = '0; dcare = '1; used = 0; m_any = 1'b0; m_last = 0;
    for (int k = 0; k < NS; k++) begin
      s = (rr + k) % NS;
      if (!m_empty[s] || (BYP && v[s])) begin
        h = m_empty[s] ? m_in[s] : q[s][0];
        if (used < NP && !taken[h.rd]) begin
          taken[h.rd]   = 1'b1;
          m_grant[s]    = 1'b1;
          m_any         = 1'b1;
          m_last        = s;
          e_we[used]    = (h.rd != 5'd0);
          e_waddr[used] = h.rd;
          if (h.rd != 5'd0) e_wdata[used] = h.data;
          else              dcare[used]   = 1'b0;
          used++;
        end
      end
    end
    #1;
    checks++;
    if (src_ready !== e_ready) begin errors++; $display("FAIL model_ready t=%0t: got %b expected %b", $time, src_ready, e_ready); end
    checks++;
    if (we !== e_we) begin errors++; $display("FAIL model_we t=%0t: got %b expected %b", $time, we, e_we); end
    checks++;
    if (waddr !== e_waddr) begin errors++; $display("FAIL model_waddr t=%0t: got %h expected %h", $time, waddr, e_waddr); end
    wd_bad = 1'b0;
    for (int p = 0; p < NP; p++) if (dcare[p] && wdata[p] !== e_wdata[p]) wd_bad = 1'b1;
    checks++;
    if (wd_bad) begin errors++; $display("FAIL model_wdata t=%0t: got %h expected %h", $time, wdata, e_wdata); end
    checks++;
    if (pending !== e_pend) begin errors++; $display("FAIL model_pending t=%0t: got %h expected %h", $time, pending, e_pend); end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < NS; i++) begin
      if (m_grant[i] && !m_empty[i]) void'(q[i].pop_front());
      if (m_acc[i] && !(m_grant[i] && m_empty[i])) q[i].push_back(m_in[i]);
    end
    if (m_any) rr = (m_last + 1) % NS;
    @(negedge clk);
  endtask

  task automatic idle_cycle();
    logic [NS-1:0][4:0]    z_rd;
    logic [NS-1:0][DW-1:0] z_d;
    z_rd = '0; z_d = '0;
    apply('0, z_rd, z_d);
    advance();
  endtask

  task automatic rand_inputs(output logic [NS-1:0][4:0] rd, output logic [NS-1:0][DW-1:0] d,
                             input int max_rd);
    for (int i = 0; i < NS; i++) begin
      rd[i] = 5'($urandom_range(0, max_rd));
      d[i]  = {$urandom, $urandom};
    end
  endtask

  // Asynchronous reset, checked before any clock edge arrives.
  task automatic do_reset();
    src_valid = '0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NS; i++) q[i].delete();
    rr = 0;
    checks++;
    if (we !== '0 || waddr !== '0 || wdata !== '0) begin errors++; $display("FAIL reset_ports: got we=%b waddr=%h expected all zero", we, waddr); end
    checks++;
    if (pending !== '0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pending); end
    checks++;
    if (src_ready !== 4'hF) begin errors++; $display("FAIL reset_ready: got %b expected 1111", src_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    bit busy;
    busy = 1'b1;
    for (int c = 0; c < 40 && busy; c++) begin
      busy = 1'b0;
      for (int i = 0; i < NS; i++) if (q[i].size() != 0) busy = 1'b1;
      if (busy) idle_cycle();
    end
    checks++;
    if (busy) begin errors++; $display("FAIL drain: model queues still hold entries after 40 cycles, expected empty"); end
  endtask

  task automatic test_reset();
    do_reset();
    idle_cycle();
    checks++;
    if (we !== '0 || pending !== '0 || src_ready !== 4'hF) begin
      errors++; $display("FAIL idle_after_reset: got we=%b pending=%h ready=%b expected 0/0/1111", we, pending, src_ready);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [NS-1:0][4:0]    rd;
    logic [NS-1:0][DW-1:0] d;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      rand_inputs(rd, d, 31);
      apply(4'hF, rd, d);
      advance();
    end
    rand_inputs(rd, d, 31);
    apply(4'hF, rd, d);
    do_reset();
    rd = '0; d = '0;
    apply('0, rd, d);
    checks++;
    if (we !== '0 || pending !== '0 || src_ready !== 4'hF) begin
      errors++; $display("FAIL mid_burst_reset: got we=%b pending=%h ready=%b expected 0/0/1111", we, pending, src_ready);
    end
    advance();
  endtask

  task automatic test_single();
    logic [NS-1:0][4:0]    rd;
    logic [NS-1:0][DW-1:0] d;
    do_reset();
    rd = '0; d = '0;
    rd[1] = 5'd5; d[1] = 64'hA5;
    for (int c = 0; c <= LAT; c++) begin
      apply((c == 0) ? 4'b0010 : 4'b0000, rd, d);
      if (c == LAT) begin
        checks++;
        if (we !== 2'b01 || waddr[0] !== 5'd5 || wdata[0] !== 64'hA5) begin
          errors++; $display("FAIL single_write: got we=%b waddr0=%0d wdata0=%h expected 01/5/a5", we, waddr[0], wdata[0]);
        end
        checks++;
        if (pending[5] !== !BYP) begin errors++; $display("FAIL single_pending: got %b expected %b", pending[5], !BYP); end
      end
      advance();
    end
    idle_cycle();
    checks++;
    if (we !== 2'b00 || pending !== '0) begin errors++; $display("FAIL single_after: got we=%b pending=%h expected 00/0", we, pending); end
  endtask

  task automatic test_round_robin();
    logic [NS-1:0][4:0]    rd;
    logic [NS-1:0][DW-1:0] d;
    int a, b;
    do_reset();
    for (int c = 0; c < LAT + 4; c++) begin
      for (int i = 0; i < NS; i++) begin rd[i] = 5'(10 + i); d[i] = {$urandom, $urandom}; end
      apply(4'hF, rd, d);
      if (c >= LAT) begin
        a = ((c - LAT) % 2 == 0) ? 0 : 2;
        b = a + 1;
        checks++;
        if (we !== 2'b11 || waddr[0] !== 5'(10 + a) || waddr[1] !== 5'(10 + b)) begin
          errors++; $display("FAIL rr_cycle%0d: got we=%b waddr=%0d,%0d expected 11/%0d,%0d", c, we, waddr[0], waddr[1], 10 + a, 10 + b);
        end
      end
      advance();
    end
    drain();
  endtask

  task automatic test_conflict();
    logic [NS-1:0][4:0]    rd;
    logic [NS-1:0][DW-1:0] d;
    do_reset();
    rd = '0; d = '0;
    rd[0] = 5'd7; rd[1] = 5'd9; rd[2] = 5'd7;
    d[0] = 64'h100; d[1] = 64'h101; d[2] = 64'h102;
    for (int c = 0; c <= LAT + 1; c++) begin
      apply((c == 0) ? 4'b0111 : 4'b0000, rd, d);
      if (c == LAT) begin
        checks++;
        if (we !== 2'b11 || waddr[0] !== 5'd7 || waddr[1] !== 5'd9 || wdata[0] !== 64'h100) begin
          errors++; $display("FAIL conflict_n: got we=%b waddr=%0d,%0d expected 11/7,9", we, waddr[0], waddr[1]);
        end
      end
      if (c == LAT + 1) begin
        checks++;
        if (we !== 2'b01 || waddr[0] !== 5'd7 || wdata[0] !== 64'h102) begin
          errors++; $display("FAIL conflict_n1: got we=%b waddr0=%0d wdata0=%h expected 01/7/102", we, waddr[0], wdata[0]);
        end
      end
      advance();
    end
    drain();
  endtask

  task automatic test_zero_reg();
    logic [NS-1:0][4:0]    rd;
    logic [NS-1:0][DW-1:0] d;
    do_reset();
    rd = '0; d = '0;
    rd[0] = 5'd3; d[0] = 64'h33;
    rd[3] = 5'd0; d[3] = 64'hDEAD;
    for (int c = 0; c <= LAT + 1; c++) begin
      apply((c == 0) ? 4'b1001 : 4'b0000, rd, d);
      if (c == LAT) begin
        checks++;
        if (we !== 2'b01 || waddr[0] !== 5'd3 || waddr[1] !== 5'd0) begin
          errors++; $display("FAIL zero_reg_port: got we=%b waddr=%0d,%0d expected 01/3,0", we, waddr[0], waddr[1]);
        end
        checks++;
        if (pending[0] !== 1'b0 || pending[3] !== !BYP) begin
          errors++; $display("FAIL zero_reg_pending: got p0=%b p3=%b expected 0/%b", pending[0], pending[3], !BYP);
        end
      end
      if (c == LAT + 1) begin
        checks++;
        if (we !== 2'b00) begin errors++; $display("FAIL zero_reg_popped: got we=%b expected 00", we); end
      end
      advance();
    end
  endtask

  task automatic test_full_stall();
    logic [NS-1:0][4:0]    rd;
    logic [NS-1:0][DW-1:0] d;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NS; i++) begin rd[i] = 5'd7; d[i] = {$urandom, $urandom}; end
      apply(4'hF, rd, d);
      if (c == 3) begin
        checks++;
        if (src_ready[0] !== 1'b0) begin errors++; $display("FAIL full_ready0: got %b expected 0", src_ready[0]); end
      end
      advance();
    end
    for (int c = 0; c < 40; c++) begin
      rand_inputs(rd, d, 3);
      for (int i = 0; i < NS; i++) if ($urandom_range(0, 3) != 0) rd[i] = 5'd7;
      apply(4'($urandom), rd, d);
      advance();
    end
    drain();
  endtask

  task automatic test_random();
    logic [NS-1:0][4:0]    rd;
    logic [NS-1:0][DW-1:0] d;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_inputs(rd, d, (c < 200) ? 7 : 31);
      apply(4'($urandom), rd, d);
      advance();
    end
    drain();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_conflict();
    test_zero_reg();
    test_full_stall();
    test_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
